// File: rtl/requant_pipe.sv
// Multi-lane requantiser: bias add, fixed-point multiply, round-shift + offset, clamp.
// Four registered stages on one global advance; a stalled output freezes every stage.
module requant_pipe #(
   parameter int LANES     = 4,
   parameter int ACC_W     = 24,
   parameter int BIAS_W    = 8,
   parameter int MUL_W     = 15,
   parameter int OUT_W     = 8,
   parameter int MAX_SHIFT = 38,
   parameter int CNT_W     = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cfg_we,
   input  logic [1:0]                cfg_addr,
   input  logic [2*OUT_W-1:0]        cfg_wdata,
   output logic                      cfg_busy,
   output logic                      cfg_err,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*ACC_W-1:0]    in_acc,
   input  logic [LANES*BIAS_W-1:0]   in_bias,
   input  logic                      in_last,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANES*OUT_W-1:0]    out_data,
   output logic                      out_last,
   output logic [CNT_W-1:0]          sat_cnt,
   input  logic                      sat_clr
);

   localparam int SH_W = $clog2(MAX_SHIFT + 1);
   localparam int S_W  = ACC_W + 1;
   localparam int P_W  = ACC_W + MUL_W + 2;
   localparam int R_W  = OUT_W + 1 + MAX_SHIFT;
   localparam int Q_W  = ((P_W > R_W) ? P_W : R_W) + 1;
   localparam int NS_W = $clog2(LANES + 1);

   typedef struct packed {
      logic [OUT_W-1:0] off;
      logic [MUL_W-1:0] mul;
      logic [SH_W-1:0]  shift;
      logic [OUT_W-1:0] amin;
      logic [OUT_W-1:0] amax;
   } cfg_t;

   localparam cfg_t CFG_RST = '{
      off:   '0,
      mul:   '0,
      shift: '0,
      amin:  {1'b1, {(OUT_W-1){1'b0}}},
      amax:  {1'b0, {(OUT_W-1){1'b1}}}
   };

   cfg_t cfg_q;
   cfg_t cfg_d;
   logic wr_ok;
   logic adv;

   logic                  s1_valid, s2_valid, s3_valid;
   logic                  s1_last, s2_last, s3_last;
   cfg_t                  s1_cfg;
   logic signed [S_W-1:0] s1_sum [LANES];
   logic [OUT_W-1:0]      s2_off;
   logic [SH_W-1:0]       s2_shift, s3_shift;
   logic [OUT_W-1:0]      s2_amin, s2_amax, s3_amin, s3_amax;
   logic signed [P_W-1:0] s2_prod [LANES];
   logic signed [Q_W-1:0] s3_q [LANES];

   logic signed [S_W-1:0] sum_d [LANES];
   logic signed [P_W-1:0] prod_d [LANES];
   logic signed [Q_W-1:0] q_d [LANES];
   logic signed [Q_W-1:0] rnd;
   logic signed [Q_W-1:0] y, amin_x, amax_x;
   logic [SH_W:0]         sh_amt;
   logic                  hi, lo;
   logic [LANES*OUT_W-1:0] data_d;
   logic [NS_W-1:0]       nsat;
   logic [CNT_W:0]        sat_sum;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;
   assign cfg_busy = s1_valid || s2_valid || s3_valid || out_valid;

   // cfg_d is what a beat accepted this cycle sees, so a same-cycle write is honoured.
   always_comb begin
      cfg_d = cfg_q;
      wr_ok = cfg_we && !cfg_busy &&
              ((cfg_addr != 2'd2) || (cfg_wdata <= (2*OUT_W)'(MAX_SHIFT)));
      if (wr_ok) begin
         case (cfg_addr)
            2'd0:    cfg_d.off   = cfg_wdata[OUT_W-1:0];
            2'd1:    cfg_d.mul   = cfg_wdata[MUL_W-1:0];
            2'd2:    cfg_d.shift = cfg_wdata[SH_W-1:0];
            default: begin
               cfg_d.amin = cfg_wdata[OUT_W-1:0];
               cfg_d.amax = cfg_wdata[2*OUT_W-1:OUT_W];
            end
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         sum_d[i] = S_W'($signed(in_acc[i*ACC_W +: ACC_W]))
                  + S_W'($signed(in_bias[i*BIAS_W +: BIAS_W]));
      end
   end

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         prod_d[i] = P_W'(s1_sum[i]) * P_W'($signed({1'b0, s1_cfg.mul}));
      end
   end

   // (2*off + 1) << shift folds the half-LSB rounding term and the offset into one add.
   always_comb begin
      rnd = {{(Q_W-OUT_W-1){s2_off[OUT_W-1]}}, s2_off, 1'b1};
      for (int i = 0; i < LANES; i++) begin
         q_d[i] = Q_W'(s2_prod[i]) + (rnd <<< s2_shift);
      end
   end

   always_comb begin
      data_d = '0;
      nsat   = '0;
      y      = '0;
      hi     = 1'b0;
      lo     = 1'b0;
      amin_x = Q_W'($signed(s3_amin));
      amax_x = Q_W'($signed(s3_amax));
      sh_amt = (SH_W+1)'(s3_shift) + (SH_W+1)'(1);
      for (int i = 0; i < LANES; i++) begin
         y  = s3_q[i] >>> sh_amt;
         hi = (y > amax_x);
         lo = (y < amin_x);
         if ((amin_x > amax_x) || hi) begin
            data_d[i*OUT_W +: OUT_W] = s3_amax;
         end else if (lo) begin
            data_d[i*OUT_W +: OUT_W] = s3_amin;
         end else begin
            data_d[i*OUT_W +: OUT_W] = y[OUT_W-1:0];
         end
         nsat = nsat + NS_W'(hi || lo);
      end
      sat_sum = {1'b0, sat_cnt} + (CNT_W+1)'(nsat);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_q     <= CFG_RST;
         cfg_err   <= 1'b0;
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         s3_valid  <= 1'b0;
         out_valid <= 1'b0;
         s1_last   <= 1'b0;
         s2_last   <= 1'b0;
         s3_last   <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         sat_cnt   <= '0;
         s1_cfg    <= CFG_RST;
         s2_off    <= '0;
         s2_shift  <= '0;
         s3_shift  <= '0;
         s2_amin   <= '0;
         s2_amax   <= '0;
         s3_amin   <= '0;
         s3_amax   <= '0;
         for (int i = 0; i < LANES; i++) begin
            s1_sum[i]  <= '0;
            s2_prod[i] <= '0;
            s3_q[i]    <= '0;
         end
      end else begin
         cfg_q <= cfg_d;
         if (cfg_we && !wr_ok) begin
            cfg_err <= 1'b1;
         end
         if (adv) begin
            s1_valid <= in_valid;
            s1_last  <= in_valid && in_last;
            s1_cfg   <= cfg_d;
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_off   <= s1_cfg.off;
            s2_shift <= s1_cfg.shift;
            s2_amin  <= s1_cfg.amin;
            s2_amax  <= s1_cfg.amax;
            s3_valid <= s2_valid;
            s3_last  <= s2_last;
            s3_shift <= s2_shift;
            s3_amin  <= s2_amin;
            s3_amax  <= s2_amax;
            out_valid <= s3_valid;
            out_last  <= s3_valid && s3_last;
            if (s3_valid) begin
               out_data <= data_d;
            end
            for (int i = 0; i < LANES; i++) begin
               s1_sum[i]  <= sum_d[i];
               s2_prod[i] <= prod_d[i];
               s3_q[i]    <= q_d[i];
            end
         end
         if (sat_clr) begin
            sat_cnt <= '0;
         end else if (adv && s3_valid) begin
            sat_cnt <= sat_sum[CNT_W] ? {CNT_W{1'b1}} : sat_sum[CNT_W-1:0];
         end
      end
   end

endmodule

// File: tb/tb_requant_pipe.sv
// Bench for requant_pipe: directed arithmetic/boundary beats plus randomized traffic,
// every cycle checked against a queue-based behavioural model.
module tb_requant_pipe;

   localparam int LANES     = 4;
   localparam int ACC_W     = 24;
   localparam int BIAS_W    = 8;
   localparam int MUL_W     = 15;
   localparam int OUT_W     = 8;
   localparam int MAX_SHIFT = 38;
   localparam int CNT_W     = 6;
   localparam int CNT_MAX   = (1 << CNT_W) - 1;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    cfg_we = 1'b0;
   logic [1:0]              cfg_addr = '0;
   logic [2*OUT_W-1:0]      cfg_wdata = '0;
   logic                    cfg_busy, cfg_err;
   logic                    in_valid = 1'b0;
   logic                    in_ready;
   logic [LANES*ACC_W-1:0]  in_acc = '0;
   logic [LANES*BIAS_W-1:0] in_bias = '0;
   logic                    in_last = 1'b0;
   logic                    out_valid;
   logic                    out_ready = 1'b1;
   logic [LANES*OUT_W-1:0]  out_data;
   logic                    out_last;
   logic [CNT_W-1:0]        sat_cnt;
   logic                    sat_clr = 1'b0;

   requant_pipe #(
      .LANES(LANES), .ACC_W(ACC_W), .BIAS_W(BIAS_W), .MUL_W(MUL_W),
      .OUT_W(OUT_W), .MAX_SHIFT(MAX_SHIFT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .cfg_busy(cfg_busy), .cfg_err(cfg_err),
      .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc),
      .in_bias(in_bias), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .sat_cnt(sat_cnt), .sat_clr(sat_clr)
   );

   always #5 clk = ~clk;

   int vec = 0;
   int err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vec++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Behavioural model: config registers, beats in flight with their stage position.
   typedef struct {
      logic [LANES*OUT_W-1:0] dat;
      logic                   last;
      int                     nsat;
      int                     k;
   } ent_t;

   ent_t pq[$];
   int   m_off, m_mul, m_shift, m_min, m_max, m_sat;
   bit   m_err;
   int   n_out = 0, n_last = 0, last_at = 0;

   function automatic logic [LANES*OUT_W-1:0] model_beat(
      input logic [LANES*ACC_W-1:0] a, input logic [LANES*BIAS_W-1:0] b, output int ns);
      logic [LANES*OUT_W-1:0] r;
      longint s, p, y;
      r  = '0;
      ns = 0;
      for (int i = 0; i < LANES; i++) begin
         s = longint'($signed(a[i*ACC_W +: ACC_W])) + longint'($signed(b[i*BIAS_W +: BIAS_W]));
         p = s * longint'(m_mul);
         y = ((p + (longint'(1) << m_shift)) >>> (m_shift + 1)) + longint'(m_off);
         if (y > m_max || y < m_min) ns++;
         if (m_min > m_max) y = m_max;
         else if (y > m_max) y = m_max;
         else if (y < m_min) y = m_min;
         r[i*OUT_W +: OUT_W] = y[OUT_W-1:0];
      end
      return r;
   endfunction

   always @(negedge clk) begin
      bit   ov, adv, busy;
      int   add;
      ent_t e;
      if (!rst_n) begin
         pq.delete();
         m_off = 0; m_mul = 0; m_shift = 0; m_min = -128; m_max = 127;
         m_sat = 0; m_err = 0;
         chk("rst_out_valid", out_valid, 0);
         chk("rst_cfg_busy", cfg_busy, 0);
         chk("rst_cfg_err", cfg_err, 0);
         chk("rst_sat_cnt", sat_cnt, 0);
         chk("rst_out_data", out_data, 0);
         chk("rst_out_last", out_last, 0);
      end else begin
         ov   = (pq.size() != 0) && (pq[0].k == 3);
         busy = (pq.size() != 0);
         chk("out_valid", out_valid, ov);
         chk("in_ready", in_ready, !ov || out_ready);
         chk("cfg_busy", cfg_busy, busy);
         chk("cfg_err", cfg_err, m_err);
         chk("sat_cnt", sat_cnt, m_sat);
         if (ov) begin
            chk("out_data", out_data, pq[0].dat);
            chk("out_last", out_last, pq[0].last);
         end
         if (out_valid && out_ready) begin
            n_out++;
            if (out_last) begin
               n_last++;
               last_at = n_out;
            end
         end
         // State as it will be after the coming rising edge.
         if (cfg_we) begin
            if (!busy && (cfg_addr != 2'd2 || cfg_wdata <= MAX_SHIFT)) begin
               case (cfg_addr)
                  2'd0: m_off = int'($signed(cfg_wdata[OUT_W-1:0]));
                  2'd1: m_mul = int'(cfg_wdata[MUL_W-1:0]);
                  2'd2: m_shift = int'(cfg_wdata);
                  default: begin
                     m_min = int'($signed(cfg_wdata[OUT_W-1:0]));
                     m_max = int'($signed(cfg_wdata[2*OUT_W-1:OUT_W]));
                  end
               endcase
            end else begin
               m_err = 1'b1;
            end
         end
         adv = !ov || out_ready;
         add = 0;
         if (adv) begin
            if (ov) void'(pq.pop_front());
            foreach (pq[i]) begin
               if (pq[i].k < 3) begin
                  pq[i].k = pq[i].k + 1;
                  if (pq[i].k == 3) add += pq[i].nsat;
               end
            end
            if (in_valid) begin
               e.dat  = model_beat(in_acc, in_bias, e.nsat);
               e.last = in_last;
               e.k    = 0;
               pq.push_back(e);
            end
         end
         if (sat_clr) m_sat = 0;
         else m_sat = (m_sat + add > CNT_MAX) ? CNT_MAX : m_sat + add;
      end
   end

   bit rand_ready = 1'b0;
   always @(posedge clk) begin
      #1;
      out_ready = rand_ready ? ($urandom_range(0, 9) < 6) : 1'b1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_wr(input logic [1:0] a, input logic [15:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      step();
      cfg_we = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (cfg_busy && n < 500) begin
         step();
         n++;
      end
      chk("drain_idle", cfg_busy, 0);
   endtask

   task automatic send(input logic [LANES*ACC_W-1:0] a, input logic [LANES*BIAS_W-1:0] b,
                       input logic l);
      bit ok = 1'b0;
      int n = 0;
      in_valid = 1'b1; in_acc = a; in_bias = b; in_last = l;
      while (!ok && n < 1000) begin
         @(negedge clk);
         ok = in_ready;
         step();
         n++;
      end
      in_valid = 1'b0; in_last = 1'b0;
      if (!ok) chk("send_accept", 0, 1);
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (!out_valid && n < 50) begin
         step();
         n++;
      end
      chk("wait_out_valid", out_valid, 1);
   endtask

   function automatic logic [LANES*ACC_W-1:0] rep_acc(input int v);
      logic [31:0] t = v;
      logic [LANES*ACC_W-1:0] r;
      for (int i = 0; i < LANES; i++) r[i*ACC_W +: ACC_W] = t[ACC_W-1:0];
      return r;
   endfunction

   function automatic logic [LANES*BIAS_W-1:0] rep_bias(input int v);
      logic [31:0] t = v;
      logic [LANES*BIAS_W-1:0] r;
      for (int i = 0; i < LANES; i++) r[i*BIAS_W +: BIAS_W] = t[BIAS_W-1:0];
      return r;
   endfunction

   initial begin
      int n, n0, l0;
      logic [LANES*ACC_W-1:0]  a;
      logic [LANES*BIAS_W-1:0] b;
      logic [31:0] t;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_sat_cnt", sat_cnt, 0);
      rst_n = 1'b1;
      step();

      // Basic: offset -3, mul 16384, shift 14; 105 * 0.5 rounds to 53, minus 3.
      cfg_wr(2'd0, 16'h00FD);
      cfg_wr(2'd1, 16'd16384);
      cfg_wr(2'd2, 16'd14);
      send(rep_acc(100), rep_bias(5), 1'b0);
      wait_out(n);
      chk("latency", n + 1, 4);
      chk("basic_data", out_data, 32'h32323232);
      chk("basic_sat", sat_cnt, 0);

      // Negative clamp: -500 - 3 = -503 clamps to -128 in every lane.
      drain();
      cfg_wr(2'd3, 16'h7F80);
      send(rep_acc(-1000), rep_bias(0), 1'b0);
      wait_out(n);
      chk("neg_clamp_data", out_data, 32'h80808080);
      chk("neg_clamp_sat", sat_cnt, LANES);

      // Rounding ties: -0.5 -> 0, +0.5 -> 1 (even lanes +1, odd lanes -1).
      drain();
      cfg_wr(2'd0, 16'h0000);
      for (int i = 0; i < LANES; i++) begin
         t = (i % 2 == 0) ? 32'd1 : 32'hFFFF_FFFF;
         a[i*ACC_W +: ACC_W] = t[ACC_W-1:0];
      end
      send(a, rep_bias(0), 1'b0);
      wait_out(n);
      chk("round_tie_data", out_data, 32'h00010001);

      // Inverted bounds (min 20, max 5): output pinned to act_max.
      drain();
      cfg_wr(2'd3, 16'h0514);
      send(rep_acc(100), rep_bias(5), 1'b0);
      wait_out(n);
      chk("inverted_bounds", out_data, 32'h05050505);
      drain();
      cfg_wr(2'd3, 16'h7F80);

      // Backpressure stream of 10 beats with a rejected mid-stream mul write.
      drain();
      chk("err_before_busy_write", cfg_err, 0);
      rand_ready = 1'b1;
      n0 = n_out;
      l0 = n_last;
      for (int k = 0; k < 10; k++) begin
         for (int i = 0; i < LANES; i++) begin
            t = k * 50 - 200 + i;
            a[i*ACC_W +: ACC_W] = t[ACC_W-1:0];
         end
         if (k == 5) begin
            cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = 16'd100;
         end
         send(a, rep_bias($urandom_range(0, 255)), k == 9);
         cfg_we = 1'b0;
      end
      drain();
      rand_ready = 1'b0;
      chk("busy_write_err", cfg_err, 1);
      chk("stream_count", n_out - n0, 10);
      chk("stream_last_count", n_last - l0, 1);
      chk("stream_last_pos", last_at - n0, 10);

      // Randomized traffic with occasional idle reconfiguration.
      rand_ready = 1'b1;
      for (int blk = 0; blk < 6; blk++) begin
         in_valid = 1'b0;
         drain();
         cfg_wr(2'd0, 16'($urandom_range(0, 255)));
         cfg_wr(2'd1, 16'($urandom_range(0, 32767)));
         cfg_wr(2'd2, 16'($urandom_range(10, 30)));
         cfg_wr(2'd3, 16'($urandom_range(0, 65535)));
         for (int c = 0; c < 120; c++) begin
            for (int i = 0; i < LANES; i++) begin
               t = $urandom;
               a[i*ACC_W +: ACC_W] = t[ACC_W-1:0];
               b[i*BIAS_W +: BIAS_W] = t[31:24];
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            in_acc    = a;
            in_bias   = b;
            in_last   = ($urandom_range(0, 7) == 0);
            sat_clr   = ($urandom_range(0, 49) == 0);
            cfg_we    = ($urandom_range(0, 29) == 0);
            cfg_addr  = 2'($urandom_range(0, 3));
            cfg_wdata = 16'($urandom_range(0, 63));
            step();
         end
         in_valid = 1'b0; in_last = 1'b0; sat_clr = 1'b0; cfg_we = 1'b0;
      end
      drain();
      rand_ready = 1'b0;
      step();

      // Reset with three beats in flight, after narrowing the bounds.
      cfg_wr(2'd0, 16'h0000);
      cfg_wr(2'd1, 16'd16384);
      cfg_wr(2'd2, 16'd14);
      cfg_wr(2'd3, 16'h649C);
      send(rep_acc(10), rep_bias(0), 1'b0);
      send(rep_acc(20), rep_bias(0), 1'b0);
      send(rep_acc(30), rep_bias(0), 1'b1);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_busy", cfg_busy, 0);
      step();
      step();
      rst_n = 1'b1;
      step();
      chk("post_rst_sat", sat_cnt, 0);
      chk("post_rst_err", cfg_err, 0);
      repeat (6) step();
      chk("no_stale_beat", out_valid, 0);
      // Defaults: mul 0 gives 0.
      send(rep_acc(100), rep_bias(5), 1'b0);
      wait_out(n);
      chk("default_mul_zero", out_data, 32'h00000000);
      // Restored default bounds clamp -500 to -128.
      drain();
      cfg_wr(2'd1, 16'd16384);
      cfg_wr(2'd2, 16'd14);
      send(rep_acc(-1000), rep_bias(0), 1'b0);
      wait_out(n);
      chk("default_bounds", out_data, 32'h80808080);

      // Illegal shift while idle: rejected, shift stays 14 (105/2 rounds to 53).
      drain();
      cfg_wr(2'd2, 16'd39);
      chk("shift39_err", cfg_err, 1);
      send(rep_acc(100), rep_bias(5), 1'b0);
      wait_out(n);
      chk("shift39_ignored", out_data, 32'h35353535);
      drain();
      repeat (2) step();

      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule

// File: doc/requant_pipe.md
Name: requant_pipe

Overview:
- Parametrised neuron-finalising pipeline: takes LANES raw MAC sums per beat, adds per-lane bias, multiplies by a fixed-point multiplier, applies rounding shift plus output offset, clamps to the activation range, and emits LANES quantised activations.
- Next-generation replacement for the single-lane, fixed-width finalising path in the network processor.
- Adds full valid/ready backpressure, multi-lane operation, configurable clamp bounds, a guarded config write port, and saturation statistics.

Parameters:
LANES, 4, parallel neurons per beat (1..27)
ACC_W, 24, signed width of each incoming MAC sum
BIAS_W, 8, signed width of each bias
MUL_W, 15, unsigned multiplier width
OUT_W, 8, signed output activation width
MAX_SHIFT, 38, largest legal shift value
CNT_W, 16, saturation counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  config write strobe
cfg_addr  in  2  0=out_offset, 1=mul, 2=shift, 3={act_max,act_min}
cfg_wdata  in  2*OUT_W  config data; low bits used per field
cfg_busy  out  1  any pipeline stage holds valid data
cfg_err  out  1  sticky: write rejected
in_valid  in  1  input beat valid
in_ready  out  1  pipeline accepts beat
in_acc  in  LANES*ACC_W  signed sums, lane 0 in LSBs
in_bias  in  LANES*BIAS_W  signed biases
in_last  in  1  last beat of layer
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_data  out  LANES*OUT_W  signed activations
out_last  out  1  in_last delayed with its beat
sat_cnt  out  CNT_W  lanes clamped since reset or clear
sat_clr  in  1  synchronous clear of sat_cnt

Behaviour:
- Reset (rst_n low, async): every stage valid=0, out_valid=0, out_data=0, out_last=0, cfg_busy=0, cfg_err=0, sat_cnt=0.
- Reset config values: out_offset=0, mul=0, shift=0, act_min=-(2^(OUT_W-1)), act_max=2^(OUT_W-1)-1.
- Reset mid-operation discards all in-flight beats without emitting them.
- Pipeline has 4 registered stages with one global advance enable: adv = !out_valid || out_ready; in_ready = adv.
- A beat transfers on in_valid && in_ready. Latency is exactly 4 cycles from accept to out_valid when out_ready is held high. Throughput is 1 beat/cycle.
- While out_valid && !out_ready, all stages hold and out_data/out_last stay stable. No beat is dropped or duplicated.
- S1: s = acc + sign-extended bias (ACC_W+1 bits).
- S2: p = s * $signed({1'b0, mul}) (ACC_W+MUL_W+2 bits).
- S3: q = p + ((2*out_offset + 1) << shift), computed at full width with no overflow.
- S4: y = q >>> (shift+1), i.e. round-half-up(p / 2^(shift+1)) + out_offset. Output = clamp(y, act_min, act_max).
- A lane counts as saturated when y > act_max or y < act_min.
- sat_cnt adds the number of saturated lanes in each beat on the cycle that beat enters the output register. It saturates at 2^CNT_W-1. sat_clr wins over a same-cycle increment.
- cfg_busy = OR of all stage valids, including out_valid.
- A cfg write is applied only when cfg_busy=0 and, for addr 2, cfg_wdata <= MAX_SHIFT. Otherwise the write is ignored and cfg_err is set until reset.
- A cfg write on the same cycle as an in_valid acceptance is applied, and the accepted beat uses the new value. Config is latched into S1 alongside the beat so it is constant per beat.
- For addr 3, act_min = low OUT_W bits and act_max = high OUT_W bits. If act_min > act_max, output = act_max.
- out_last pulses with the beat carrying in_last. No other in-band effect.

Test Plan:
- Basic arithmetic: cfg out_offset=-3, mul=16384, shift=14; LANES beat acc=100, bias=5 -> out_data lanes all 50, out_valid exactly 4 cycles after accept, sat_cnt=0.
- Negative clamp: same config; acc=-1000, bias=0, act_min=-128 -> y=-503, output -128. sat_cnt increments by LANES.
- Rounding tie: out_offset=0, mul=16384, shift=14; acc=-1, bias=0 -> 0. With acc=1 -> 1 (half rounds up).
- Backpressure: stream 10 beats with distinct acc values while out_ready toggles randomly -> exactly 10 outputs, in order, stable while stalled, out_last only on beat 10.
- Config guard: write shift=39 when idle -> ignored, cfg_err=1. Write mul mid-stream (busy) -> ignored, cfg_err=1, outputs unchanged.
- Reset mid-stream: deassert rst_n with 3 beats in flight -> out_valid=0 immediately; after release no stale beat appears, config returns to defaults, sat_cnt=0.
